// File: rtl/ext_pipe.sv
// Registered, flow-controlled immediate extender with output + skid buffering (1-cycle latency).
// Optional illegal-mode tracking (out_ill / sticky err) is enabled by defining EXT_ILL_TRAP_EN.
module ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int SHAMT  = 2,
  parameter int TAG_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [2:0]        in_eop,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_ill,
  output logic              err
);

  localparam int PAD_W = DATA_W - IMM_W;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  // ---------------------------------------------------------------
  // Extension candidates, one per legal mode, built bit by bit
  // ---------------------------------------------------------------
  logic [DATA_W-1:0] sext_data;
  logic [DATA_W-1:0] zext_data;
  logic [DATA_W-1:0] high_data;
  logic [DATA_W-1:0] branch_data;
  logic [DATA_W-1:0] byte_data;
  logic [DATA_W-1:0] ext_data;
  logic              ext_ill;

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ext_bits
      if (gi < IMM_W) begin : g_low
        assign sext_data[gi] = in_imm[gi];
        assign zext_data[gi] = in_imm[gi];
      end else begin : g_high
        assign sext_data[gi] = in_imm[IMM_W-1];
        assign zext_data[gi] = 1'b0;
      end

      if (gi >= PAD_W) begin : g_hi_imm
        assign high_data[gi] = in_imm[gi-PAD_W];
      end else begin : g_hi_pad
        assign high_data[gi] = 1'b0;
      end

      // Bits of the sign-extended value pushed past DATA_W-1 simply fall off.
      if (gi >= SHAMT) begin : g_br_shift
        assign branch_data[gi] = sext_data[gi-SHAMT];
      end else begin : g_br_zero
        assign branch_data[gi] = 1'b0;
      end

      if (gi < 8) begin : g_byte_low
        assign byte_data[gi] = in_imm[gi];
      end else begin : g_byte_sign
        assign byte_data[gi] = in_imm[7];
      end
    end
  endgenerate

  always_comb begin
    ext_data = '0;
    ext_ill  = 1'b0;
    case (in_eop)
      3'b000:  ext_data = sext_data;
      3'b001:  ext_data = zext_data;
      3'b010:  ext_data = high_data;
      3'b011:  ext_data = branch_data;
      3'b100:  ext_data = byte_data;
      default: ext_ill  = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------
  // Two-entry buffer: OUT drives the outputs, SKID absorbs one beat of backpressure
  // ---------------------------------------------------------------
  state_t            state_reg;
  logic              in_ready_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [TAG_W-1:0]  out_tag_reg;
  logic [DATA_W-1:0] skid_data_reg;
  logic [TAG_W-1:0]  skid_tag_reg;
`ifdef EXT_ILL_TRAP_EN
  logic              out_ill_reg;
  logic              skid_ill_reg;
  logic              err_reg;
`endif

  logic in_xfer;
  logic out_xfer;

  assign out_valid = (state_reg != EMPTY);
  assign in_ready  = in_ready_reg;
  assign in_xfer   = in_valid & in_ready_reg;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b0;
      out_data_reg  <= '0;
      out_tag_reg   <= '0;
      skid_data_reg <= '0;
      skid_tag_reg  <= '0;
`ifdef EXT_ILL_TRAP_EN
      out_ill_reg   <= 1'b0;
      skid_ill_reg  <= 1'b0;
      err_reg       <= 1'b0;
`endif
    end else begin
      in_ready_reg <= 1'b1;
`ifdef EXT_ILL_TRAP_EN
      // A beat leaving in a flush cycle still counts as delivered.
      if (out_xfer && out_ill_reg) begin
        err_reg <= 1'b1;
      end
`endif
      if (flush) begin
        state_reg <= EMPTY;
      end else begin
        case (state_reg)
          EMPTY: begin
            if (in_xfer) begin
              out_data_reg <= ext_data;
              out_tag_reg  <= in_tag;
`ifdef EXT_ILL_TRAP_EN
              out_ill_reg  <= ext_ill;
`endif
              state_reg    <= ONE;
            end
          end
          ONE: begin
            if (in_xfer && out_xfer) begin
              out_data_reg <= ext_data;
              out_tag_reg  <= in_tag;
`ifdef EXT_ILL_TRAP_EN
              out_ill_reg  <= ext_ill;
`endif
            end else if (in_xfer) begin
              skid_data_reg <= ext_data;
              skid_tag_reg  <= in_tag;
`ifdef EXT_ILL_TRAP_EN
              skid_ill_reg  <= ext_ill;
`endif
              state_reg     <= FULL;
              in_ready_reg  <= 1'b0;
            end else if (out_xfer) begin
              state_reg <= EMPTY;
            end
          end
          FULL: begin
            if (out_xfer) begin
              out_data_reg <= skid_data_reg;
              out_tag_reg  <= skid_tag_reg;
`ifdef EXT_ILL_TRAP_EN
              out_ill_reg  <= skid_ill_reg;
`endif
              state_reg    <= ONE;
            end else begin
              in_ready_reg <= 1'b0;
            end
          end
          default: state_reg <= EMPTY;
        endcase
      end
    end
  end

  assign out_data = out_data_reg;
  assign out_tag  = out_tag_reg;

`ifdef EXT_ILL_TRAP_EN
  assign out_ill = out_ill_reg;
  assign err     = err_reg;
`else
  // Illegal modes still yield zero data; nothing is tracked.
  assign out_ill = 1'b0;
  assign err     = 1'b0;
  logic unused_ill;
  assign unused_ill = ext_ill;
`endif

endmodule
